// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared widths, register index type and operand-fetch FSM states
package pipeline_pkg;
    localparam int XLEN = 32;
    localparam int XCNT = 32;
    localparam int IDXW = $clog2(XCNT);
    typedef logic [IDXW-1:0] regidx_t;
    typedef enum logic [1:0] {IDLE, HAZARD, READ, OUT} state_t;
endpackage

// File: rtl/operand_fetch_if.sv
// operand_fetch_if: decoder, register-file read, writeback and execute handshakes
interface operand_fetch_if #(
    parameter int XLEN = pipeline_pkg::XLEN,
    parameter int IW = $clog2(pipeline_pkg::XCNT)
);
    import pipeline_pkg::*;
    logic DEC_VALID, DEC_READY;
    logic [IW-1:0] DEC_RS1, DEC_RS2, DEC_RD;
    logic [31:0] DEC_PAYLOAD;
    logic [IW-1:0] RCH1_IDX, RCH2_IDX;
    logic RCH1_REQ, RCH2_REQ, RCH1_RESP, RCH2_RESP;
    logic [XLEN-1:0] RCH1_VAL, RCH2_VAL;
    logic WB_VALID;
    logic [IW-1:0] WB_IDX;
    logic EX_VALID, EX_READY;
    logic [XLEN-1:0] EX_RS1_VAL, EX_RS2_VAL;
    logic [IW-1:0] EX_RD;
    logic [31:0] EX_PAYLOAD;
    modport slave (
        input DEC_VALID, DEC_RS1, DEC_RS2, DEC_RD, DEC_PAYLOAD,
        input RCH1_RESP, RCH2_RESP, RCH1_VAL, RCH2_VAL,
        input WB_VALID, WB_IDX, EX_READY,
        output DEC_READY, RCH1_IDX, RCH2_IDX, RCH1_REQ, RCH2_REQ,
        output EX_VALID, EX_RS1_VAL, EX_RS2_VAL, EX_RD, EX_PAYLOAD
    );
    modport master (
        output DEC_VALID, DEC_RS1, DEC_RS2, DEC_RD, DEC_PAYLOAD,
        output RCH1_RESP, RCH2_RESP, RCH1_VAL, RCH2_VAL,
        output WB_VALID, WB_IDX, EX_READY,
        input DEC_READY, RCH1_IDX, RCH2_IDX, RCH1_REQ, RCH2_REQ,
        input EX_VALID, EX_RS1_VAL, EX_RS2_VAL, EX_RD, EX_PAYLOAD
    );
endinterface

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register busy bits, set on issue, cleared on writeback
module reg_scoreboard #(
    parameter int XCNT = pipeline_pkg::XCNT,
    localparam int IW = $clog2(XCNT)
) (
    input  logic            CLK,
    input  logic            RSTN,
    input  logic            set_en,
    input  logic [IW-1:0]   set_idx,
    input  logic            clr_en,
    input  logic [IW-1:0]   clr_idx,
    output logic [XCNT-1:0] busy
);
    import pipeline_pkg::*;
    logic [XCNT-1:0] busy_n;
    // set beats clear on the same index; register 0 is never tracked
    always_comb begin
        busy_n = busy;
        for (int i = 1; i < XCNT; i++)
            busy_n[i] = (set_en && set_idx == IW'(i)) ? 1'b1 :
                        (clr_en && clr_idx == IW'(i)) ? 1'b0 : busy[i];
    end
    // busy table register
    always_ff @(posedge CLK or posedge RSTN)
        if (RSTN) busy <= '0;
        else busy <= busy_n;
endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: waits out RAW hazards, reads both sources, hands operands to execute
module operand_fetch #(
    parameter int XLEN = pipeline_pkg::XLEN,
    parameter int XCNT = pipeline_pkg::XCNT
) (
    input logic CLK,
    input logic RSTN,
    operand_fetch_if.slave bus
);
    import pipeline_pkg::*;
    localparam int IW = $clog2(XCNT);
    state_t state, state_n;
    logic [IW-1:0] rs1, rs2, rd;
    logic [31:0] payload;
    logic [XLEN-1:0] v1, v2;
    logic [XCNT-1:0] busy;
    logic p1, p2, stall, go, accept, ex_fire, done1, done2;
    assign stall = (rs1 != '0 && busy[rs1]) || (rs2 != '0 && busy[rs2]);
    assign go = state == HAZARD && !stall;
    assign accept = bus.DEC_VALID && bus.DEC_READY;
    assign ex_fire = bus.EX_VALID && bus.EX_READY;
    assign done1 = !p1 || bus.RCH1_RESP;
    assign done2 = !p2 || bus.RCH2_RESP;
    assign bus.DEC_READY = state == IDLE && !RSTN;
    assign bus.RCH1_REQ = (go && rs1 != '0) || (state == READ && p1);
    assign bus.RCH2_REQ = (go && rs2 != '0) || (state == READ && p2);
    assign bus.RCH1_IDX = rs1;
    assign bus.RCH2_IDX = rs2;
    assign bus.EX_VALID = state == OUT;
    assign bus.EX_RS1_VAL = v1;
    assign bus.EX_RS2_VAL = v2;
    assign bus.EX_RD = rd;
    assign bus.EX_PAYLOAD = payload;
    // walk IDLE -> HAZARD -> READ -> OUT, skipping READ when no source is used
    always_comb
        state_n = state == IDLE   ? (accept ? HAZARD : IDLE) :
                  state == HAZARD ? (stall ? HAZARD : (rs1 == '0 && rs2 == '0) ? OUT : READ) :
                  state == READ   ? ((done1 && done2) ? OUT : READ) :
                                    (ex_fire ? IDLE : OUT);
    // instruction latch, outstanding-request flags and operand capture
    always_ff @(posedge CLK or posedge RSTN)
        if (RSTN) begin
            state <= IDLE;
            rs1 <= '0;
            rs2 <= '0;
            rd <= '0;
            payload <= '0;
            v1 <= '0;
            v2 <= '0;
            p1 <= 1'b0;
            p2 <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                rs1 <= bus.DEC_RS1;
                rs2 <= bus.DEC_RS2;
                rd <= bus.DEC_RD;
                payload <= bus.DEC_PAYLOAD;
                v1 <= '0;
                v2 <= '0;
            end
            if (go) begin
                p1 <= rs1 != '0;
                p2 <= rs2 != '0;
            end
            if (state == READ && p1 && bus.RCH1_RESP) begin
                v1 <= bus.RCH1_VAL;
                p1 <= 1'b0;
            end
            if (state == READ && p2 && bus.RCH2_RESP) begin
                v2 <= bus.RCH2_VAL;
                p2 <= 1'b0;
            end
        end
    reg_scoreboard #(.XCNT(XCNT)) u_sb (
        .CLK(CLK),
        .RSTN(RSTN),
        .set_en(ex_fire && rd != '0),
        .set_idx(rd),
        .clr_en(bus.WB_VALID),
        .clr_idx(bus.WB_IDX),
        .busy(busy)
    );
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed vector table plus hazard, set/clear and reset sequences
module tb_operand_fetch;
    import pipeline_pkg::*;
    typedef struct {
        int rs1, rs2, rd, d1, d2, hold, lat;
        logic [31:0] pl, e1, e2;
    } vec_t;
    logic CLK = 1'b0;
    logic RSTN = 1'b1;
    logic spur = 1'b0;
    int d1 = 1, d2 = 1, checks = 0, failures = 0;
    logic [31:0] mem [32];
    vec_t vecs [6];
    operand_fetch_if bus ();
    operand_fetch dut (.CLK(CLK), .RSTN(RSTN), .bus(bus));
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%h required=0x%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic issue(input int r1, input int r2, input int rd, input logic [31:0] pl);
        int n;
        n = 0;
        while (!bus.DEC_READY && n < 20) begin
            tick();
            n++;
        end
        check("dec_ready_wait", 32'(bus.DEC_READY), 1);
        bus.DEC_VALID = 1'b1;
        bus.DEC_RS1 = regidx_t'(r1);
        bus.DEC_RS2 = regidx_t'(r2);
        bus.DEC_RD = regidx_t'(rd);
        bus.DEC_PAYLOAD = pl;
        tick();
        bus.DEC_VALID = 1'b0;
    endtask

    task automatic wait_ex(output int lat);
        lat = 1;
        while (!bus.EX_VALID && lat < 40) begin
            tick();
            lat++;
        end
        check("ex_valid_seen", 32'(bus.EX_VALID), 1);
    endtask

    // register file responder: answers after d cycles of REQ, or spuriously when spur is set
    initial begin
        int s1, s2;
        s1 = 0;
        s2 = 0;
        bus.RCH1_RESP = 1'b0;
        bus.RCH2_RESP = 1'b0;
        bus.RCH1_VAL = '0;
        bus.RCH2_VAL = '0;
        forever begin
            @(posedge CLK);
            #1;
            if (spur && !bus.RCH1_REQ) begin
                bus.RCH1_RESP = 1'b1; bus.RCH1_VAL = 32'hDEAD_BEEF; s1 = 0;
            end else if (bus.RCH1_REQ && s1 >= d1) begin
                bus.RCH1_RESP = 1'b1; bus.RCH1_VAL = mem[bus.RCH1_IDX]; s1 = 0;
            end else begin
                bus.RCH1_RESP = 1'b0; bus.RCH1_VAL = 32'hBAD0_0001; s1 = bus.RCH1_REQ ? s1 + 1 : 0;
            end
            if (spur && !bus.RCH2_REQ) begin
                bus.RCH2_RESP = 1'b1; bus.RCH2_VAL = 32'hDEAD_BEEF; s2 = 0;
            end else if (bus.RCH2_REQ && s2 >= d2) begin
                bus.RCH2_RESP = 1'b1; bus.RCH2_VAL = mem[bus.RCH2_IDX]; s2 = 0;
            end else begin
                bus.RCH2_RESP = 1'b0; bus.RCH2_VAL = 32'hBAD0_0002; s2 = bus.RCH2_REQ ? s2 + 1 : 0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int lat;
        logic ok_s, ok_n, ok_h, p1, p2, q1, q2;
        for (int i = 0; i < 32; i++) mem[i] = 32'h5A00_0000 + 32'(i);
        mem[3] = 32'h11;
        mem[5] = 32'h22;
        //            rs1 rs2 rd d1 d2 hold lat payload        e1             e2
        vecs[0] = '{3,  5,  7, 1, 1, 0,  3, 32'hCAFE_0001, 32'h11,        32'h22};
        vecs[1] = '{0,  0,  0, 1, 1, 0,  2, 32'h1234_5678, 32'h0,         32'h0};
        vecs[2] = '{9,  2,  4, 4, 1, 0,  6, 32'h0000_0042, 32'h5A00_0009, 32'h5A00_0002};
        vecs[3] = '{1,  0, 31, 2, 1, 5,  4, 32'hFFFF_FFFF, 32'h5A00_0001, 32'h0};
        vecs[4] = '{0, 31,  1, 1, 1, 0,  3, 32'h8000_0000, 32'h0,         32'h5A00_001F};
        vecs[5] = '{6,  6,  0, 1, 3, 0,  5, 32'h0BAD_F00D, 32'h5A00_0006, 32'h5A00_0006};
        bus.DEC_VALID = 1'b0;
        bus.DEC_RS1 = '0;
        bus.DEC_RS2 = '0;
        bus.DEC_RD = '0;
        bus.DEC_PAYLOAD = '0;
        bus.WB_VALID = 1'b0;
        bus.WB_IDX = '0;
        bus.EX_READY = 1'b0;
        repeat (2) tick();
        check("rst_dec_ready", 32'(bus.DEC_READY), 0);
        check("rst_req1", 32'(bus.RCH1_REQ), 0);
        check("rst_req2", 32'(bus.RCH2_REQ), 0);
        check("rst_ex_valid", 32'(bus.EX_VALID), 0);
        check("rst_ex_rs1", bus.EX_RS1_VAL, 0);
        check("rst_ex_payload", bus.EX_PAYLOAD, 0);
        check("rst_busy", dut.busy, 0);
        RSTN = 1'b0;
        #1;
        check("dec_ready_after_rst", 32'(bus.DEC_READY), 1);

        for (int i = 0; i < 6; i++) begin
            v = vecs[i];
            d1 = v.d1;
            d2 = v.d2;
            ok_s = 1'b1; ok_n = 1'b1; ok_h = 1'b1;
            p1 = 1'b0; p2 = 1'b0; q1 = 1'b0; q2 = 1'b0;
            issue(v.rs1, v.rs2, v.rd, v.pl);
            lat = 1;
            while (!bus.EX_VALID && lat < 40) begin
                if ((p1 && !bus.RCH1_REQ) || (q1 && bus.RCH1_REQ) ||
                    (bus.RCH1_REQ && bus.RCH1_IDX != regidx_t'(v.rs1))) ok_s = 1'b0;
                if ((p2 && !bus.RCH2_REQ) || (q2 && bus.RCH2_REQ) ||
                    (bus.RCH2_REQ && bus.RCH2_IDX != regidx_t'(v.rs2))) ok_s = 1'b0;
                if ((v.rs1 == 0 && bus.RCH1_REQ) || (v.rs2 == 0 && bus.RCH2_REQ)) ok_n = 1'b0;
                p1 = bus.RCH1_REQ && !bus.RCH1_RESP;
                q1 = bus.RCH1_REQ && bus.RCH1_RESP;
                p2 = bus.RCH2_REQ && !bus.RCH2_RESP;
                q2 = bus.RCH2_REQ && bus.RCH2_RESP;
                tick();
                lat++;
            end
            check($sformatf("v%0d_latency", i), lat, v.lat);
            check($sformatf("v%0d_req_stable", i), 32'(ok_s), 1);
            check($sformatf("v%0d_no_req_unused", i), 32'(ok_n), 1);
            for (int h = 0; h < v.hold; h++) begin
                if (!bus.EX_VALID || bus.DEC_READY || bus.EX_RS1_VAL != v.e1 || bus.EX_RS2_VAL != v.e2 ||
                    bus.EX_RD != regidx_t'(v.rd) || bus.EX_PAYLOAD != v.pl) ok_h = 1'b0;
                tick();
            end
            check($sformatf("v%0d_ex_hold", i), 32'(ok_h), 1);
            check($sformatf("v%0d_ex_rs1", i), bus.EX_RS1_VAL, v.e1);
            check($sformatf("v%0d_ex_rs2", i), bus.EX_RS2_VAL, v.e2);
            check($sformatf("v%0d_ex_rd", i), 32'(bus.EX_RD), v.rd);
            check($sformatf("v%0d_ex_payload", i), bus.EX_PAYLOAD, v.pl);
            bus.EX_READY = 1'b1;
            tick();
            bus.EX_READY = 1'b0;
            check($sformatf("v%0d_busy_set", i), 32'(dut.busy[v.rd]), 32'(v.rd != 0));
            check($sformatf("v%0d_dec_ready_idle", i), 32'(bus.DEC_READY), 1);
            bus.WB_VALID = 1'b1;
            bus.WB_IDX = regidx_t'(v.rd);
            tick();
            bus.WB_VALID = 1'b0;
            check($sformatf("v%0d_busy_clr", i), dut.busy, 0);
        end

        d1 = 1;
        d2 = 1;
        issue(3, 0, 7, 32'h0000_0A0A);
        wait_ex(lat);
        bus.EX_READY = 1'b1;
        tick();
        bus.EX_READY = 1'b0;
        check("busy7_set", 32'(dut.busy[7]), 1);
        issue(7, 0, 8, 32'h0000_0B0B);
        spur = 1'b1;
        ok_h = 1'b1;
        repeat (4) begin
            if (bus.RCH1_REQ || bus.EX_VALID || bus.DEC_READY) ok_h = 1'b0;
            tick();
        end
        spur = 1'b0;
        check("hazard_stall", 32'(ok_h), 1);
        bus.WB_VALID = 1'b1;
        bus.WB_IDX = regidx_t'(7);
        check("no_req_wb_cycle", 32'(bus.RCH1_REQ), 0);
        tick();
        bus.WB_VALID = 1'b0;
        check("req_after_wb", 32'(bus.RCH1_REQ), 1);
        check("idx_after_wb", 32'(bus.RCH1_IDX), 7);
        wait_ex(lat);
        check("stall_rs1", bus.EX_RS1_VAL, 32'h5A00_0007);
        check("stall_rs2", bus.EX_RS2_VAL, 0);
        bus.EX_READY = 1'b1;
        bus.WB_VALID = 1'b1;
        bus.WB_IDX = regidx_t'(8);
        tick();
        bus.EX_READY = 1'b0;
        bus.WB_VALID = 1'b0;
        check("set_wins", 32'(dut.busy[8]), 1);

        d1 = 10;
        d2 = 10;
        issue(3, 5, 0, 32'h0000_0C0C);
        tick();
        check("read_req1", 32'(bus.RCH1_REQ), 1);
        check("read_req2", 32'(bus.RCH2_REQ), 1);
        #1 RSTN = 1'b1;
        #1;
        check("midrst_req1", 32'(bus.RCH1_REQ), 0);
        check("midrst_req2", 32'(bus.RCH2_REQ), 0);
        check("midrst_dec_ready", 32'(bus.DEC_READY), 0);
        check("midrst_ex_valid", 32'(bus.EX_VALID), 0);
        check("midrst_busy", dut.busy, 0);
        tick();
        RSTN = 1'b0;
        #1;
        check("midrst_release_ready", 32'(bus.DEC_READY), 1);
        d1 = 1;
        d2 = 1;
        issue(3, 5, 2, 32'h0000_0D0D);
        wait_ex(lat);
        check("recover_latency", lat, 3);
        check("recover_rs1", bus.EX_RS1_VAL, 32'h11);
        check("recover_rs2", bus.EX_RS2_VAL, 32'h22);
        bus.EX_READY = 1'b1;
        tick();
        bus.EX_READY = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have parameter XLEN, default 32, register data width.
REQ-002 SHALL have parameter XCNT, default 32, architectural register count; index width is $clog2(XCNT).
REQ-003 SHALL have port CLK  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port RSTN  in  1  reset; asynchronous, active-high (asserted = 1).
REQ-005 SHALL have port DEC_VALID  in  1  decoder offers instruction.
REQ-006 SHALL have port DEC_READY  out  1  block accepts instruction.
REQ-007 SHALL have ports DEC_RS1 / DEC_RS2  in  idx  source indices; 0 = unused.
REQ-008 SHALL have port DEC_RD  in  idx  destination index; 0 = no write.
REQ-009 SHALL have port DEC_PAYLOAD  in  32  opaque decoded fields, passed through.
REQ-010 SHALL have ports RCH1_IDX / RCH2_IDX  out  idx  register file read index.
REQ-011 SHALL have ports RCH1_REQ / RCH2_REQ  out  1  read request per channel.
REQ-012 SHALL have ports RCH1_RESP / RCH2_RESP  in  1  register file read response.
REQ-013 SHALL have ports RCH1_VAL / RCH2_VAL  in  XLEN  read data, valid while RESP = 1.
REQ-014 SHALL have ports WB_VALID / WB_IDX  in  1 / idx  writeback retire, clears busy bit.
REQ-015 SHALL have ports EX_VALID / EX_READY  out / in  1  downstream handshake.
REQ-016 SHALL have ports EX_RS1_VAL / EX_RS2_VAL  out  XLEN  fetched operands.
REQ-017 SHALL have ports EX_RD / EX_PAYLOAD  out  idx / 32  forwarded destination and payload.

Function
REQ-018 SHALL implement FSM IDLE -> HAZARD -> READ -> OUT -> IDLE.
REQ-019 IDLE: DEC_READY = 1 only here; DEC_VALID & DEC_READY latches RS1/RS2/RD/PAYLOAD, next HAZARD.
REQ-020 HAZARD: stall while any nonzero source has busy bit set; busy compared against registered table, a WB clear is visible the following cycle.
REQ-021 HAZARD exit: raise RCHn_REQ for each nonzero source, next READ; if both sources 0, next OUT directly.
REQ-022 READ: RCHn_REQ and RCHn_IDX held stable until RCHn_RESP = 1; that cycle RCHn_VAL is captured and RCHn_REQ drops next cycle.
REQ-023 Channels complete independently, either order or same cycle; OUT entered cycle after both done.
REQ-024 RESP on a channel without outstanding REQ SHALL be ignored.
REQ-025 Unused (index 0) operand SHALL read as 0 with no request issued.
REQ-026 OUT: EX_VALID = 1, all EX_* stable until EX_READY = 1; on handshake next IDLE.
REQ-027 On EX handshake with EX_RD != 0, busy[EX_RD] SHALL set.
REQ-028 WB_VALID clears busy[WB_IDX] in every state; WB_IDX = 0 ignored.
REQ-029 Same-cycle set and clear of one index: set wins.
REQ-030 Latency with single-cycle responder, no stall: accept at cycle 0, REQ at 1, capture at 2, EX_VALID at 3.

Reset
REQ-031 While RSTN = 1: state IDLE, all busy bits 0, DEC_READY 0, RCHn_REQ 0, EX_VALID 0, all data outputs 0; DEC_READY = 1 first cycle after release.
REQ-032 Reset mid-operation SHALL abandon the instruction and drop outstanding requests immediately.

Structure
REQ-033 Shared package pipeline_pkg SHALL hold XLEN, XCNT, regidx_t and the FSM state enum.
REQ-034 Busy table SHALL be sub-module reg_scoreboard (set port, clear port, 32-bit busy vector).

Verification
REQ-035 RS1=3, RS2=5, RD=7, responder returns 0x11/0x22 one cycle later -> EX_VALID at cycle 3, EX_RS1_VAL=0x11, EX_RS2_VAL=0x22, busy[7]=1 after handshake.
REQ-036 Second instruction RS1=7 while busy[7] -> held in HAZARD, no RCH1_REQ; WB_VALID, WB_IDX=7 -> REQ issued one cycle later.
REQ-037 RS1=0, RS2=0 -> no REQ, operands 0, EX_VALID two cycles after accept.
REQ-038 RCH2_RESP 3 cycles before RCH1_RESP -> both values correct, REQ/IDX stable until each RESP.
REQ-039 EX_READY low 5 cycles -> EX_* unchanged, DEC_READY 0 throughout.
REQ-040 RSTN asserted during READ -> REQ low, busy clear, IDLE with DEC_READY=1 after release.
